actor_loc_ctrl: RTL and testbench

Grid-position controller for one maze actor (Pac-Man or a ghost) on the tile map. It is parametrised in map size, start tile, counter width and edge wrap. It buffers the requested direction and keeps moving along the current heading. Each move is a tile lookup plus a RAM redraw handshake, and it counts pills eaten. It sits between the input/AI logic, the map-lookup port and the RAM write module.

---
 rtl/actor_loc_ctrl_pkg.sv | 34 +++
 rtl/actor_loc_ctrl_if.sv | 35 +++
 rtl/actor_loc_ctrl_grid_step.sv | 72 +++++++
 rtl/actor_loc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_actor_loc_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/actor_loc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loc_pkg
// Description : Shared types for the maze actor controllers. It holds the tile
//               encoding returned by the map lookup port, the travel
//               directions, and the move FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package loc_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WALL  = 2'd1,
        PILL  = 2'd2,
        POWER = 2'd3
    } tile_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } loc_state_t;

endpackage : loc_pkg
`default_nettype wire

// File: rtl/actor_loc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : actor_loc_ctrl_if
// Description : Tile-lookup and redraw handshake between an actor controller
//               (master) and the map/RAM side (slave).
//                 q_valid/q_x/q_y      : one-cycle lookup request
//                 rsp_valid/rsp_tile   : lookup result strobe
//                 wr_req/wr_ack        : redraw request level / completion
// Revision    : 1.0 - initial release
// ============================================================================
interface actor_loc_ctrl_if
    import loc_pkg::*;
#(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           q_valid;
    logic [X_W-1:0] q_x;
    logic [Y_W-1:0] q_y;
    logic           rsp_valid;
    tile_t          rsp_tile;
    logic           wr_req;
    logic           wr_ack;

    modport master (
        output q_valid, q_x, q_y, wr_req,
        input  rsp_valid, rsp_tile, wr_ack
    );

    modport slave (
        input  q_valid, q_x, q_y, wr_req,
        output rsp_valid, rsp_tile, wr_ack
    );
endinterface : actor_loc_ctrl_if
`default_nettype wire

// File: rtl/actor_loc_ctrl_grid_step.sv
`default_nettype none
// ============================================================================
// Module      : grid_step
// Description : Combinational neighbour-tile calculator. Given a tile (x, y)
//               and a direction it returns the adjacent tile (tx, ty). Edges
//               sit at 0 and X_MAX/Y_MAX. With WRAP=1 the edges wrap to the
//               opposite side. With WRAP=0 off_map is raised instead and
//               tx/ty stay equal to x/y.
//               Ports: x, y, dir in; tx, ty, off_map out.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_step
    import loc_pkg::*;
#(
    parameter int X_W   = 6,
    parameter int Y_W   = 5,
    parameter int X_MAX = 39,
    parameter int Y_MAX = 29,
    parameter bit WRAP  = 1'b1
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  dir_t           dir,
    output logic [X_W-1:0] tx,
    output logic [Y_W-1:0] ty,
    output logic           off_map
);
    localparam logic [X_W-1:0] c_x_last = X_W'(X_MAX);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(Y_MAX);

    always_comb begin
        tx      = x;
        ty      = y;
        off_map = 1'b0;
        case (dir)
            UP: begin
                if (y == '0) begin
                    if (WRAP) ty = c_y_last;
                    else      off_map = 1'b1;
                end else begin
                    ty = y - Y_W'(1);
                end
            end
            DOWN: begin
                if (y == c_y_last) begin
                    if (WRAP) ty = '0;
                    else      off_map = 1'b1;
                end else begin
                    ty = y + Y_W'(1);
                end
            end
            LEFT: begin
                if (x == '0) begin
                    if (WRAP) tx = c_x_last;
                    else      off_map = 1'b1;
                end else begin
                    tx = x - X_W'(1);
                end
            end
            RIGHT: begin
                if (x == c_x_last) begin
                    if (WRAP) tx = '0;
                    else      off_map = 1'b1;
                end else begin
                    tx = x + X_W'(1);
                end
            end
            default: ;
        endcase
    end
endmodule : grid_step
`default_nettype wire

// File: rtl/actor_loc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : actor_loc_ctrl
// Description : Grid-position controller for one maze actor. It buffers the
//               requested direction and keeps moving along the current
//               heading. Each move on step is a tile lookup followed by a RAM
//               redraw handshake. It counts pills and power pills eaten.
//               Ports: CLOCK_50, reset (async, active-low); up/down/left/
//               right/step requests; loc_bus lookup + redraw handshake;
//               curr/next position, heading, pill_count, power pulse, busy.
// Revision    : 1.0 - initial release
// ============================================================================
module actor_loc_ctrl
    import loc_pkg::*;
#(
    parameter int X_W     = 6,
    parameter int Y_W     = 5,
    parameter int X_MAX   = 39,
    parameter int Y_MAX   = 29,
    parameter int START_X = 20,
    parameter int START_Y = 20,
    parameter bit WRAP    = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic                 step,
    actor_loc_ctrl_if.master     loc_bus,
    output logic [X_W-1:0]       curr_x,
    output logic [Y_W-1:0]       curr_y,
    output logic [X_W-1:0]       next_x,
    output logic [Y_W-1:0]       next_y,
    output dir_t                 heading,
    output logic [CNT_W-1:0]     pill_count,
    output logic                 power,
    output logic                 busy
);
    localparam logic [X_W-1:0]   c_start_x = X_W'(START_X);
    localparam logic [Y_W-1:0]   c_start_y = Y_W'(START_Y);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    loc_state_t       r_state;
    logic [X_W-1:0]   r_curr_x, r_next_x, r_tx;
    logic [Y_W-1:0]   r_curr_y, r_next_y, r_ty;
    dir_t             r_heading, r_queued, r_try;
    tile_t            r_tile;
    logic [CNT_W-1:0] r_pill_count;
    logic             r_q_valid, r_wr_req, r_power, r_busy;

    dir_t             w_req_dir, w_sel_dir;
    logic [X_W-1:0]   w_try_x, w_head_x;
    logic [Y_W-1:0]   w_try_y, w_head_y;
    logic             w_try_off, w_head_off, w_commit;

    // Fixed-priority decode of the level direction inputs.
    always_comb begin
        w_req_dir = NONE;
        if      (up)    w_req_dir = UP;
        else if (down)  w_req_dir = DOWN;
        else if (left)  w_req_dir = LEFT;
        else if (right) w_req_dir = RIGHT;
    end

    // A buffered turn takes precedence over continuing straight.
    assign w_sel_dir = (r_queued != NONE) ? r_queued : r_heading;
    assign w_commit  = (r_state == S_WRITE) && loc_bus.wr_ack;

    // Two neighbour calculators. The heading target is needed alongside the
    // first choice so that a blocked or off-map turn can fall back to
    // travelling straight without extra cycles.
    grid_step #(
        .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .WRAP(WRAP)
    ) u_try_step (
        .x(r_curr_x), .y(r_curr_y), .dir(w_sel_dir),
        .tx(w_try_x), .ty(w_try_y), .off_map(w_try_off)
    );

    grid_step #(
        .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .WRAP(WRAP)
    ) u_head_step (
        .x(r_curr_x), .y(r_curr_y), .dir(r_heading),
        .tx(w_head_x), .ty(w_head_y), .off_map(w_head_off)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_curr_x     <= c_start_x;
            r_curr_y     <= c_start_y;
            r_next_x     <= c_start_x;
            r_next_y     <= c_start_y;
            r_tx         <= c_start_x;
            r_ty         <= c_start_y;
            r_heading    <= NONE;
            r_queued     <= NONE;
            r_try        <= NONE;
            r_tile       <= EMPTY;
            r_pill_count <= '0;
            r_q_valid    <= 1'b0;
            r_wr_req     <= 1'b0;
            r_power      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_q_valid <= 1'b0;
            r_power   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (step && (w_sel_dir != NONE)) begin
                        if (!w_try_off) begin
                            r_try     <= w_sel_dir;
                            r_tx      <= w_try_x;
                            r_ty      <= w_try_y;
                            r_q_valid <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_REQ;
                        end else if ((w_sel_dir != r_heading) && (r_heading != NONE)
                                     && !w_head_off) begin
                            // Off-map turn acts as a wall: go straight instead.
                            r_try     <= r_heading;
                            r_tx      <= w_head_x;
                            r_ty      <= w_head_y;
                            r_q_valid <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            r_heading <= NONE;
                        end
                    end
                end

                S_REQ: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (loc_bus.rsp_valid) begin
                        if (loc_bus.rsp_tile == WALL) begin
                            if ((r_try != r_heading) && (r_heading != NONE) && !w_head_off) begin
                                r_try     <= r_heading;
                                r_tx      <= w_head_x;
                                r_ty      <= w_head_y;
                                r_q_valid <= 1'b1;
                                r_state   <= S_REQ;
                            end else begin
                                r_heading <= NONE;
                                r_busy    <= 1'b0;
                                r_state   <= S_IDLE;
                            end
                        end else begin
                            r_next_x <= r_tx;
                            r_next_y <= r_ty;
                            r_tile   <= loc_bus.rsp_tile;
                            r_wr_req <= 1'b1;
                            r_state  <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (loc_bus.wr_ack) begin
                        r_curr_x  <= r_next_x;
                        r_curr_y  <= r_next_y;
                        r_heading <= r_try;
                        if (((r_tile == PILL) || (r_tile == POWER)) && (r_pill_count != c_cnt_max))
                            r_pill_count <= r_pill_count + CNT_W'(1);
                        r_power  <= (r_tile == POWER);
                        r_wr_req <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase

            // Queue: the taken turn is consumed on commit, but a request
            // present in the same cycle is kept since it is newer.
            if (w_commit && (r_try == r_queued))
                r_queued <= NONE;
            if (w_req_dir != NONE)
                r_queued <= w_req_dir;
        end
    end

    assign loc_bus.q_valid = r_q_valid;
    assign loc_bus.q_x     = r_tx;
    assign loc_bus.q_y     = r_ty;
    assign loc_bus.wr_req  = r_wr_req;
    assign curr_x          = r_curr_x;
    assign curr_y          = r_curr_y;
    assign next_x          = r_next_x;
    assign next_y          = r_next_y;
    assign heading         = r_heading;
    assign pill_count      = r_pill_count;
    assign power           = r_power;
    assign busy            = r_busy;

endmodule : actor_loc_ctrl
`default_nettype wire

// File: tb/tb_actor_loc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_actor_loc_ctrl
// Description : Self-checking bench for actor_loc_ctrl. A wrapping 40x30
//               instance is driven by directed and random moves against a
//               tile map held in the bench. A second non-wrapping instance
//               with a 2-bit counter covers wall edges and count saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_actor_loc_ctrl;
    import loc_pkg::*;

    localparam int c_xn = 40;
    localparam int c_yn = 30;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Wrapping instance
    logic        up = 0, down = 0, left = 0, right = 0, step = 0;
    logic [5:0]  curr_x, next_x;
    logic [4:0]  curr_y, next_y;
    dir_t        heading;
    logic [15:0] pill_count;
    logic        power, busy;
    actor_loc_ctrl_if #(.X_W(6), .Y_W(5)) bus ();

    actor_loc_ctrl u_dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .up(up), .down(down), .left(left), .right(right), .step(step),
        .loc_bus(bus),
        .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x), .next_y(next_y),
        .heading(heading), .pill_count(pill_count), .power(power), .busy(busy)
    );

    // Non-wrapping instance, start at the right edge, 2-bit pill counter
    logic        nw_up = 0, nw_down = 0, nw_left = 0, nw_right = 0, nw_step = 0;
    logic [5:0]  nw_curr_x, nw_next_x;
    logic [4:0]  nw_curr_y, nw_next_y;
    dir_t        nw_heading;
    logic [1:0]  nw_pill_count;
    logic        nw_power, nw_busy;
    actor_loc_ctrl_if #(.X_W(6), .Y_W(5)) nw_bus ();

    actor_loc_ctrl #(
        .START_X(39), .START_Y(5), .WRAP(1'b0), .CNT_W(2)
    ) u_dut_nw (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .up(nw_up), .down(nw_down), .left(nw_left), .right(nw_right), .step(nw_step),
        .loc_bus(nw_bus),
        .curr_x(nw_curr_x), .curr_y(nw_curr_y), .next_x(nw_next_x), .next_y(nw_next_y),
        .heading(nw_heading), .pill_count(nw_pill_count), .power(nw_power), .busy(nw_busy)
    );

    // Reference model state
    tile_t map [0:c_xn-1][0:c_yn-1];
    int    m_x, m_y, m_cnt;
    dir_t  m_head, m_queue;
    int    n_vec = 0;
    int    n_err = 0;
    int    last_edges;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic dir_t m_prio(input logic [3:0] b);
        if (b[3]) return UP;
        if (b[2]) return DOWN;
        if (b[1]) return LEFT;
        if (b[0]) return RIGHT;
        return NONE;
    endfunction

    // Neighbour tile with toroidal wrap, from plain modular arithmetic.
    function automatic void m_target(input int x, input int y, input dir_t d,
                                     output int tx, output int ty);
        int dx, dy;
        dx = (d == RIGHT) ? 1 : (d == LEFT) ? -1 : 0;
        dy = (d == DOWN)  ? 1 : (d == UP)   ? -1 : 0;
        tx = (x + dx + c_xn) % c_xn;
        ty = (y + dy + c_yn) % c_yn;
    endfunction

    task automatic press(input logic [3:0] b);
        {up, down, left, right} = b;
        @(negedge CLOCK_50);
        {up, down, left, right} = 4'b0;
        if (b != 4'b0) m_queue = m_prio(b);
    endtask

    // One step of the wrapping instance, acting as map port and RAM writer.
    task automatic do_move(input int rsp_lat, input int ack_lat, input logic [3:0] mid);
        dir_t  try_d;
        int    tx, ty, edges;
        bit    done;
        tile_t t;
        step = 1'b1;
        @(negedge CLOCK_50);
        step  = 1'b0;
        edges = 1;
        if (m_queue == NONE && m_head == NONE) begin
            chk("idle_qv", bus.q_valid, 1'b0);
            @(negedge CLOCK_50);
            chk("idle_busy", busy, 1'b0);
            return;
        end
        try_d = (m_queue != NONE) ? m_queue : m_head;
        done  = 1'b0;
        while (!done) begin
            m_target(m_x, m_y, try_d, tx, ty);
            chk("q_valid", bus.q_valid, 1'b1);
            chk("q_x", bus.q_x, tx);
            chk("q_y", bus.q_y, ty);
            @(negedge CLOCK_50); edges++;
            chk("qv_pulse", bus.q_valid, 1'b0);
            for (int i = 0; i < rsp_lat; i++) begin
                bus.wr_ack = 1'($urandom_range(0, 1));
                step       = 1'($urandom_range(0, 1));
                @(negedge CLOCK_50); edges++;
            end
            bus.wr_ack    = 1'b0;
            step          = 1'b0;
            t             = map[tx][ty];
            bus.rsp_valid = 1'b1;
            bus.rsp_tile  = t;
            @(negedge CLOCK_50); edges++;
            bus.rsp_valid = 1'b0;
            bus.rsp_tile  = tile_t'(2'($urandom_range(0, 3)));
            if (t == WALL) begin
                if (try_d != m_head && m_head != NONE) begin
                    try_d = m_head;
                end else begin
                    m_head = NONE;
                    chk("blk_wr_req", bus.wr_req, 1'b0);
                    chk("blk_busy", busy, 1'b0);
                    chk("blk_heading", heading, NONE);
                    chk("blk_cnt", pill_count, m_cnt);
                    chk("blk_curr_x", curr_x, m_x);
                    done = 1'b1;
                end
            end else begin
                chk("wr_req", bus.wr_req, 1'b1);
                chk("next_x", next_x, tx);
                chk("next_y", next_y, ty);
                chk("curr_hold", curr_x, m_x);
                for (int i = 0; i < ack_lat; i++) begin
                    if (i == 0 && mid != 4'b0) begin
                        {up, down, left, right} = mid;
                        m_queue = m_prio(mid);
                    end else begin
                        {up, down, left, right} = 4'b0;
                    end
                    bus.rsp_valid = 1'($urandom_range(0, 1));
                    bus.rsp_tile  = WALL;
                    @(negedge CLOCK_50); edges++;
                end
                {up, down, left, right} = 4'b0;
                bus.rsp_valid = 1'b0;
                bus.wr_ack    = 1'b1;
                @(negedge CLOCK_50); edges++;
                bus.wr_ack = 1'b0;
                m_x    = tx;
                m_y    = ty;
                m_head = try_d;
                if (try_d == m_queue) m_queue = NONE;
                if ((t == PILL || t == POWER) && m_cnt < 65535) m_cnt++;
                map[tx][ty] = EMPTY;
                chk("curr_x", curr_x, m_x);
                chk("curr_y", curr_y, m_y);
                chk("next_eq", next_x, m_x);
                chk("heading", heading, m_head);
                chk("pill_count", pill_count, m_cnt);
                chk("power", power, (t == POWER));
                chk("wr_req_drop", bus.wr_req, 1'b0);
                chk("busy_drop", busy, 1'b0);
                last_edges = edges;
                @(negedge CLOCK_50);
                chk("power_once", power, 1'b0);
                done = 1'b1;
            end
        end
    endtask

    task automatic nw_move(input tile_t t, input int ex);
        nw_step = 1'b1;
        @(negedge CLOCK_50);
        nw_step = 1'b0;
        chk("nw_qv", nw_bus.q_valid, 1'b1);
        chk("nw_qx", nw_bus.q_x, ex);
        @(negedge CLOCK_50);
        nw_bus.rsp_valid = 1'b1;
        nw_bus.rsp_tile  = t;
        @(negedge CLOCK_50);
        nw_bus.rsp_valid = 1'b0;
        chk("nw_wr_req", nw_bus.wr_req, 1'b1);
        nw_bus.wr_ack = 1'b1;
        @(negedge CLOCK_50);
        nw_bus.wr_ack = 1'b0;
        chk("nw_curr_x", nw_curr_x, ex);
    endtask

    task automatic nw_press(input logic [3:0] b);
        {nw_up, nw_down, nw_left, nw_right} = b;
        @(negedge CLOCK_50);
        {nw_up, nw_down, nw_left, nw_right} = 4'b0;
    endtask

    initial begin
        bus.rsp_valid    = 1'b0;
        bus.rsp_tile     = EMPTY;
        bus.wr_ack       = 1'b0;
        nw_bus.rsp_valid = 1'b0;
        nw_bus.rsp_tile  = EMPTY;
        nw_bus.wr_ack    = 1'b0;
        for (int x = 0; x < c_xn; x++)
            for (int y = 0; y < c_yn; y++)
                map[x][y] = EMPTY;
        m_x = 20; m_y = 20; m_cnt = 0; m_head = NONE; m_queue = NONE;

        // Reset held with step asserted
        step = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_curr_x", curr_x, 20);
        chk("rst_curr_y", curr_y, 20);
        chk("rst_next_x", next_x, 20);
        chk("rst_cnt", pill_count, 0);
        chk("rst_qv", bus.q_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_heading", heading, NONE);
        step = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);

        // Non-wrapping edge and counter saturation
        chk("nw_rst_x", nw_curr_x, 39);
        chk("nw_rst_y", nw_curr_y, 5);
        nw_press(4'b0001);
        nw_step = 1'b1;
        @(negedge CLOCK_50);
        nw_step = 1'b0;
        chk("nw_off_qv", nw_bus.q_valid, 1'b0);
        @(negedge CLOCK_50);
        chk("nw_off_busy", nw_busy, 1'b0);
        nw_press(4'b0010);
        for (int i = 1; i <= 4; i++) begin
            nw_move(PILL, 39 - i);
            chk("nw_sat_cnt", nw_pill_count, (i < 3) ? i : 3);
        end
        nw_press(4'b0001);
        for (int i = 1; i <= 4; i++) nw_move(EMPTY, 35 + i);
        chk("nw_head_r", nw_heading, RIGHT);
        nw_step = 1'b1;
        @(negedge CLOCK_50);
        nw_step = 1'b0;
        chk("nw_wall_qv", nw_bus.q_valid, 1'b0);
        @(negedge CLOCK_50);
        chk("nw_wall_qv2", nw_bus.q_valid, 1'b0);
        chk("nw_wall_head", nw_heading, NONE);
        chk("nw_wall_x", nw_curr_x, 39);

        // First move right with minimum latency
        press(4'b0001);
        do_move(0, 0, 4'b0);
        chk("lat4", last_edges, 4);
        chk("first_x", curr_x, 21);

        // Heading persistence: pill then power, buffered UP pressed in S_WRITE
        map[22][20] = PILL;
        map[23][20] = POWER;
        do_move(0, 0, 4'b0);
        do_move(1, 2, 4'b1000);
        chk("pers_cnt", pill_count, 2);

        // UP is a wall: fall back to RIGHT, queue keeps UP
        map[23][19] = WALL;
        map[24][20] = EMPTY;
        do_move(0, 1, 4'b0);
        chk("retry_x", curr_x, 24);
        map[24][19] = EMPTY;
        do_move(2, 0, 4'b0);
        chk("turn_head", heading, UP);
        chk("turn_y", curr_y, 19);

        // Blocked straight ahead, then blocked with no heading
        map[24][18] = WALL;
        do_move(0, 0, 4'b0);
        press(4'b0100);
        map[24][20] = WALL;
        do_move(0, 0, 4'b0);
        map[24][20] = EMPTY;
        do_move(0, 0, 4'b0);

        // Tunnel wrap along row 20
        for (int x = 0; x < c_xn; x++) map[x][m_y] = EMPTY;
        press(4'b0001);
        for (int i = 0; i < 40 && m_x != 39; i++) do_move(0, 0, 4'b0);
        chk("wrap_pre_x", curr_x, 39);
        do_move(0, 0, 4'b0);
        chk("wrap_x", curr_x, 0);

        // Random map, presses and handshake latencies
        for (int x = 0; x < c_xn; x++)
            for (int y = 0; y < c_yn; y++) begin
                int r;
                r = $urandom_range(0, 99);
                map[x][y] = (r < 20) ? WALL : (r < 60) ? PILL : (r < 65) ? POWER : EMPTY;
            end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1) press(4'($urandom_range(0, 15)));
            do_move(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)));
        end

        // Reset in the middle of a redraw
        press(4'b0001);
        begin
            int tx, ty;
            m_target(m_x, m_y, RIGHT, tx, ty);
            map[tx][ty] = EMPTY;
        end
        step = 1'b1;
        @(negedge CLOCK_50);
        step = 1'b0;
        @(negedge CLOCK_50);
        bus.rsp_valid = 1'b1;
        bus.rsp_tile  = EMPTY;
        @(negedge CLOCK_50);
        bus.rsp_valid = 1'b0;
        chk("mid_wr_req", bus.wr_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wr_req", bus.wr_req, 1'b0);
        chk("mid_rst_x", curr_x, 20);
        chk("mid_rst_y", curr_y, 20);
        chk("mid_rst_cnt", pill_count, 0);
        @(negedge CLOCK_50);
        reset      = 1'b1;
        bus.wr_ack = 1'b1;
        @(negedge CLOCK_50);
        bus.wr_ack = 1'b0;
        chk("late_ack_x", curr_x, 20);
        chk("late_ack_busy", busy, 1'b0);
        chk("late_ack_head", heading, NONE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_actor_loc_ctrl
`default_nettype wire
